// File: rtl/fwrisc_decode.sv
// fwrisc_decode
// Decode stage of the fwrisc pipeline. It takes one instruction per
// fetch_valid/decode_ready handshake and starts the register-file reads. It
// works out the operation class, destination register and immediate, and then
// hands execute a fully registered operand bundle over exec_valid/exec_ready.
// It also owns the program counter. It feeds next_pc/next_pc_seq back to fetch
// and takes redirects (flush) from execute.
//
// Ports
//   clock, reset            pipeline clock; asynchronous active-low reset
//   fetch_valid, instr,     instruction from fetch (instr_c: 16-bit form)
//   instr_c, decode_ready
//   next_pc, next_pc_seq    PC[31:1] for fetch; 0 on next_pc_seq = redirect
//   ra_raddr, rb_raddr      register-file read addresses (rs1, rs2)
//   ra_rdata, rb_rdata      register-file data, valid the cycle after address
//   exec_valid, exec_ready  operand bundle handshake to execute
//   op_*                    registered operand bundle
//   flush, flush_pc         single-cycle redirect from execute
module fwrisc_decode #(
    parameter logic [31:0] RESET_VEC         = 32'h8000_0000,
    parameter logic        ENABLE_COMPRESSED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    output logic        decode_ready,
    input  logic [31:0] instr,
    input  logic        instr_c,
    output logic [30:0] next_pc,
    output logic        next_pc_seq,
    output logic [4:0]  ra_raddr,
    output logic [4:0]  rb_raddr,
    input  logic [31:0] ra_rdata,
    input  logic [31:0] rb_rdata,
    output logic        exec_valid,
    input  logic        exec_ready,
    output logic [31:0] op_pc,
    output logic [31:0] op_instr,
    output logic        op_instr_c,
    output logic [3:0]  op_class,
    output logic [4:0]  op_rd,
    output logic [31:0] op_imm,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_illegal,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam logic [3:0] CLS_ALU_REG    = 4'd0;
    localparam logic [3:0] CLS_ALU_IMM    = 4'd1;
    localparam logic [3:0] CLS_LOAD       = 4'd2;
    localparam logic [3:0] CLS_STORE      = 4'd3;
    localparam logic [3:0] CLS_BRANCH     = 4'd4;
    localparam logic [3:0] CLS_JAL        = 4'd5;
    localparam logic [3:0] CLS_JALR       = 4'd6;
    localparam logic [3:0] CLS_LUI        = 4'd7;
    localparam logic [3:0] CLS_AUIPC      = 4'd8;
    localparam logic [3:0] CLS_SYSTEM     = 4'd9;
    localparam logic [3:0] CLS_FENCE      = 4'd10;
    localparam logic [3:0] CLS_COMPRESSED = 4'd14;
    localparam logic [3:0] CLS_ILLEGAL    = 4'd15;

    typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic        flush_pending;
    logic [4:0]  rs1_q, rs2_q;
    logic        accept;
    logic [3:0]  dec_class;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        unused_flush_bit;

    // Targets are always halfword aligned, so bit 0 of the redirect is dropped.
    assign unused_flush_bit = flush_pc[0];

    // A flush blocks acceptance, so a stale instruction cannot slip in while
    // the PC is being redirected.
    assign decode_ready = (state_q == IDLE) && !flush;
    assign accept       = fetch_valid && decode_ready;
    assign ra_raddr     = instr_c ? 5'd0 : instr[19:15];
    assign rb_raddr     = instr_c ? 5'd0 : instr[24:20];
    assign next_pc      = pc_q[31:1];
    assign next_pc_seq  = !flush_pending;
    assign exec_valid   = (state_q == VALID);
    assign op_illegal   = (op_class == CLS_ILLEGAL);

    // Operation class from the opcode. Every valid 32-bit opcode ends in 2'b11,
    // so a word whose low bits are not 11 falls to the ILLEGAL default.
    always_comb begin
        dec_class = CLS_ILLEGAL;
        if (instr_c) begin
            dec_class = ENABLE_COMPRESSED ? CLS_COMPRESSED : CLS_ILLEGAL;
        end else begin
            case (instr[6:0])
                7'b0110011: dec_class = CLS_ALU_REG;
                7'b0010011: dec_class = CLS_ALU_IMM;
                7'b0000011: dec_class = CLS_LOAD;
                7'b0100011: dec_class = CLS_STORE;
                7'b1100011: dec_class = CLS_BRANCH;
                7'b1101111: dec_class = CLS_JAL;
                7'b1100111: dec_class = CLS_JALR;
                7'b0110111: dec_class = CLS_LUI;
                7'b0010111: dec_class = CLS_AUIPC;
                7'b1110011: dec_class = CLS_SYSTEM;
                7'b0001111: dec_class = CLS_FENCE;
                default:    dec_class = CLS_ILLEGAL;
            endcase
        end
    end

    // Immediate and destination register, selected by class.
    always_comb begin
        dec_imm = 32'd0;
        dec_rd  = instr[11:7];
        case (dec_class)
            CLS_ALU_IMM, CLS_LOAD, CLS_JALR, CLS_SYSTEM, CLS_FENCE:
                dec_imm = {{20{instr[31]}}, instr[31:20]};
            CLS_STORE: begin
                dec_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_rd  = 5'd0;
            end
            CLS_BRANCH: begin
                dec_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
                dec_rd  = 5'd0;
            end
            CLS_LUI, CLS_AUIPC:
                dec_imm = {instr[31:12], 12'd0};
            CLS_JAL:
                dec_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            CLS_COMPRESSED, CLS_ILLEGAL:
                dec_rd  = 5'd0;
            default:
                dec_imm = 32'd0;
        endcase
    end

    // Next-state logic. A flush always wins. An accept made while a flush is
    // pending discards the stale fetch and stays in IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && !flush_pending) state_d = READ;
                READ:    state_d = VALID;
                VALID:   if (exec_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // PC, flush tracking and operand bundle. Register data arrives the cycle
    // after acceptance, so op_a/op_b are captured in READ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_VEC;
            flush_pending <= 1'b0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            op_pc         <= 32'd0;
            op_instr      <= 32'd0;
            op_instr_c    <= 1'b0;
            op_class      <= 4'd0;
            op_rd         <= 5'd0;
            op_imm        <= 32'd0;
            op_a          <= 32'd0;
            op_b          <= 32'd0;
        end else if (flush) begin
            pc_q          <= {flush_pc[31:1], 1'b0};
            flush_pending <= 1'b1;
        end else if (state_q == IDLE && accept) begin
            if (flush_pending) begin
                flush_pending <= 1'b0;
            end else begin
                rs1_q      <= ra_raddr;
                rs2_q      <= rb_raddr;
                op_pc      <= pc_q;
                op_instr   <= instr_c ? {16'd0, instr[15:0]} : instr;
                op_instr_c <= instr_c;
                op_class   <= dec_class;
                op_rd      <= dec_rd;
                op_imm     <= dec_imm;
                pc_q       <= pc_q + (instr_c ? 32'd2 : 32'd4);
            end
        end else if (state_q == READ) begin
            op_a <= (rs1_q == 5'd0) ? 32'd0 : ra_rdata;
            op_b <= (rs2_q == 5'd0) ? 32'd0 : rb_rdata;
        end
    end

endmodule

// File: tb/tb_fwrisc_decode.sv
// tb_fwrisc_decode
// Directed bench for fwrisc_decode. A second instance built with compressed
// instructions disabled sees the same stimulus, and its outputs are checked
// where they differ from the main instance.
module tb_fwrisc_decode;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] instr;
    logic        instr_c;
    logic [31:0] ra_rdata, rb_rdata;
    logic        exec_ready;
    logic        flush;
    logic [31:0] flush_pc;

    logic        decode_ready, next_pc_seq, exec_valid, op_instr_c, op_illegal;
    logic [30:0] next_pc;
    logic [4:0]  ra_raddr, rb_raddr, op_rd;
    logic [31:0] op_pc, op_instr, op_imm, op_a, op_b;
    logic [3:0]  op_class;

    logic        decode_ready_nc, next_pc_seq_nc, exec_valid_nc, op_instr_c_nc, op_illegal_nc;
    logic [30:0] next_pc_nc;
    logic [4:0]  ra_raddr_nc, rb_raddr_nc, op_rd_nc;
    logic [31:0] op_pc_nc, op_instr_nc, op_imm_nc, op_a_nc, op_b_nc;
    logic [3:0]  op_class_nc;

    int checks   = 0;
    int failures = 0;

    fwrisc_decode dut (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .decode_ready(decode_ready), .instr(instr), .instr_c(instr_c),
        .next_pc(next_pc), .next_pc_seq(next_pc_seq),
        .ra_raddr(ra_raddr), .rb_raddr(rb_raddr),
        .ra_rdata(ra_rdata), .rb_rdata(rb_rdata),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .op_pc(op_pc), .op_instr(op_instr), .op_instr_c(op_instr_c),
        .op_class(op_class), .op_rd(op_rd), .op_imm(op_imm),
        .op_a(op_a), .op_b(op_b), .op_illegal(op_illegal),
        .flush(flush), .flush_pc(flush_pc)
    );

    fwrisc_decode #(.ENABLE_COMPRESSED(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .fetch_valid(fetch_valid),
        .decode_ready(decode_ready_nc), .instr(instr), .instr_c(instr_c),
        .next_pc(next_pc_nc), .next_pc_seq(next_pc_seq_nc),
        .ra_raddr(ra_raddr_nc), .rb_raddr(rb_raddr_nc),
        .ra_rdata(ra_rdata), .rb_rdata(rb_rdata),
        .exec_valid(exec_valid_nc), .exec_ready(exec_ready),
        .op_pc(op_pc_nc), .op_instr(op_instr_nc), .op_instr_c(op_instr_c_nc),
        .op_class(op_class_nc), .op_rd(op_rd_nc), .op_imm(op_imm_nc),
        .op_a(op_a_nc), .op_b(op_b_nc), .op_illegal(op_illegal_nc),
        .flush(flush), .flush_pc(flush_pc)
    );

    // 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] ins,
                                 input logic ic, input logic er);
        fetch_valid = fv;
        instr       = ins;
        instr_c     = ic;
        exec_ready  = er;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        ra_rdata = 32'd0;
        rb_rdata = 32'd0;
        flush    = 1'b0;
        flush_pc = 32'd0;
        #3 reset = 1'b0;
        #17;
        $display("[TB] reset state");
        checkOutput("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
        checkOutput("rst_decode_ready", {31'd0, decode_ready}, 32'd1);
        checkOutput("rst_next_pc", {1'b0, next_pc}, 32'h4000_0000);
        checkOutput("rst_next_pc_seq", {31'd0, next_pc_seq}, 32'd1);
        checkOutput("rst_op_pc", op_pc, 32'd0);
        checkOutput("rst_op_class", {28'd0, op_class}, 32'd0);
        #2 reset = 1'b1;

        // addi x1,x0,5 with junk on the rs1 read port: x0 must read as 0
        $display("[TB] addi x1,x0,5");
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        ra_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("addi_ready", {31'd0, decode_ready}, 32'd1);
        checkOutput("addi_next_pc_at_accept", {1'b0, next_pc}, 32'h4000_0000);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("addi_next_pc_after", {1'b0, next_pc}, 32'h4000_0002);
        checkOutput("addi_read_valid", {31'd0, exec_valid}, 32'd0);
        tick();
        checkOutput("addi_valid", {31'd0, exec_valid}, 32'd1);
        checkOutput("addi_class", {28'd0, op_class}, 32'd1);
        checkOutput("addi_imm", op_imm, 32'd5);
        checkOutput("addi_op_a", op_a, 32'd0);
        checkOutput("addi_rd", {27'd0, op_rd}, 32'd1);
        checkOutput("addi_pc", op_pc, 32'h8000_0000);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        checkOutput("addi_done", {31'd0, exec_valid}, 32'd0);

        // asynchronous reset between clock edges clears the bundle and PC
        $display("[TB] async reset");
        reset = 1'b0;
        #2;
        checkOutput("areset_op_class", {28'd0, op_class}, 32'd0);
        checkOutput("areset_op_imm", op_imm, 32'd0);
        checkOutput("areset_next_pc", {1'b0, next_pc}, 32'h4000_0000);
        #1 reset = 1'b1;

        // compressed 16'h4505 followed by add x3,x1,x2
        $display("[TB] compressed then add");
        applyStimulus(1'b1, 32'h0000_4505, 1'b1, 1'b0);
        ra_rdata = 32'd7;
        rb_rdata = 32'd9;
        #1;
        checkOutput("c_raddr", {27'd0, ra_raddr}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("c_next_pc", {1'b0, next_pc}, 32'h4000_0001);
        tick();
        checkOutput("c_valid", {31'd0, exec_valid}, 32'd1);
        checkOutput("c_pc", op_pc, 32'h8000_0000);
        checkOutput("c_class", {28'd0, op_class}, 32'd14);
        checkOutput("c_instr", op_instr, 32'h0000_4505);
        checkOutput("c_instr_c", {31'd0, op_instr_c}, 32'd1);
        checkOutput("c_rd", {27'd0, op_rd}, 32'd0);
        checkOutput("c_illegal", {31'd0, op_illegal}, 32'd0);
        checkOutput("nc_class", {28'd0, op_class_nc}, 32'd15);
        checkOutput("nc_illegal", {31'd0, op_illegal_nc}, 32'd1);
        checkOutput("nc_rd", {27'd0, op_rd_nc}, 32'd0);
        exec_ready = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
        #1;
        checkOutput("add_raddr", {27'd0, ra_raddr}, 32'd1);
        checkOutput("add_rbaddr", {27'd0, rb_raddr}, 32'd2);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("add_pc", op_pc, 32'h8000_0002);
        checkOutput("add_class", {28'd0, op_class}, 32'd0);
        checkOutput("add_op_a", op_a, 32'd7);
        checkOutput("add_op_b", op_b, 32'd9);
        checkOutput("add_rd", {27'd0, op_rd}, 32'd3);
        checkOutput("add_imm", op_imm, 32'd0);
        checkOutput("add_next_pc", {1'b0, next_pc}, 32'h4000_0003);

        // execute stalls for 5 cycles while fetch keeps offering work
        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h0010_0113, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {31'd0, exec_valid}, 32'd1);
            checkOutput("stall_ready", {31'd0, decode_ready}, 32'd0);
            checkOutput("stall_pc", op_pc, 32'h8000_0002);
        end
        checkOutput("stall_class", {28'd0, op_class}, 32'd0);
        checkOutput("stall_next_pc", {1'b0, next_pc}, 32'h4000_0003);

        // redirect while the bundle is waiting in VALID
        $display("[TB] flush in VALID");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        flush    = 1'b1;
        flush_pc = 32'h8000_0100;
        #1;
        checkOutput("flush_ready_low", {31'd0, decode_ready}, 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_valid_drop", {31'd0, exec_valid}, 32'd0);
        checkOutput("flush_seq", {31'd0, next_pc_seq}, 32'd0);
        checkOutput("flush_next_pc", {1'b0, next_pc}, 32'h4000_0080);
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        #1;
        checkOutput("stale_ready", {31'd0, decode_ready}, 32'd1);
        tick();
        checkOutput("stale_dropped", {31'd0, exec_valid}, 32'd0);
        checkOutput("stale_seq", {31'd0, next_pc_seq}, 32'd1);
        checkOutput("stale_next_pc", {1'b0, next_pc}, 32'h4000_0080);

        // beq x0,x0,-4 at the redirect target
        $display("[TB] branch");
        applyStimulus(1'b1, 32'hFE00_0EE3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("br_valid", {31'd0, exec_valid}, 32'd1);
        checkOutput("br_pc", op_pc, 32'h8000_0100);
        checkOutput("br_class", {28'd0, op_class}, 32'd4);
        checkOutput("br_imm", op_imm, 32'hFFFF_FFFC);
        checkOutput("br_rd", {27'd0, op_rd}, 32'd0);
        checkOutput("br_op_a", op_a, 32'd0);
        checkOutput("br_next_pc", {1'b0, next_pc}, 32'h4000_0082);
        exec_ready = 1'b1;
        tick();

        // all-ones word: unknown opcode
        $display("[TB] illegal word");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("ill_class", {28'd0, op_class}, 32'd15);
        checkOutput("ill_flag", {31'd0, op_illegal}, 32'd1);
        checkOutput("ill_imm", op_imm, 32'd0);
        checkOutput("ill_rd", {27'd0, op_rd}, 32'd0);
        checkOutput("ill_pc", op_pc, 32'h8000_0104);

        // flush arriving with the exec handshake; bit 0 of the target is dropped
        $display("[TB] flush with handshake");
        flush      = 1'b1;
        flush_pc   = 32'h8000_0201;
        exec_ready = 1'b1;
        tick();
        flush      = 1'b0;
        exec_ready = 1'b0;
        checkOutput("fh_valid", {31'd0, exec_valid}, 32'd0);
        checkOutput("fh_next_pc", {1'b0, next_pc}, 32'h4000_0100);
        checkOutput("fh_seq", {31'd0, next_pc_seq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
